// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB encodings and the SRAM slave state type.
package ahb_sram_slave_pkg;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LAST,
        ERR1,
        ERR2
    } sram_state_t;

endpackage

// File: rtl/ahb_sram_slave_bytelane.sv
// Byte-lane enable and alignment decode for one AHB transfer on a 32-bit bus.
module ahb_sram_bytelane
    import ahb_sram_slave_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] byte_en,
    output logic       misalign
);

    always_comb begin
        byte_en  = 4'b0000;
        misalign = 1'b0;
        case (hsize)
            HSIZE_BYTE: byte_en = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = addr_lo[0];
            end
            HSIZE_WORD: begin
                byte_en  = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// Word-organised SRAM AHB slave with programmable wait states and two-cycle ERROR.
// Optional write protection of the lower quarter is enabled with AHB_SRAM_WRPROT_EN.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic                  Hsel,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hready,
`ifdef AHB_SRAM_WRPROT_EN
    input  logic                  Hwprot,
`endif
    output logic                  Hreadyout,
    output logic [1:0]            Hresp,
    output logic [DATA_WIDTH-1:0] Hrdata
);

    localparam int                  IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(MEM_DEPTH);
    localparam logic [3:0]          WS      = 4'(WAIT_STATES);

    sram_state_t           state_q, state_d, launch_state;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-3:0] word_idx;
    logic [3:0]            lane_en;
    logic                  misalign;
    logic                  accept;
    logic                  xfer_err;
    logic                  mem_we;

    assign word_idx = Haddr[ADDR_WIDTH-1:2];

    ahb_sram_bytelane u_bytelane (
        .hsize    (Hsize),
        .addr_lo  (Haddr[1:0]),
        .byte_en  (lane_en),
        .misalign (misalign)
    );

    always_comb begin
        accept   = Hsel && Hready && ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));
        xfer_err = (word_idx >= DEPTH_W) || (Hsize > HSIZE_WORD) || misalign;
`ifdef AHB_SRAM_WRPROT_EN
        if (Hwrite && Hwprot && (word_idx < (ADDR_WIDTH-2)'(MEM_DEPTH / 4)))
            xfer_err = 1'b1;
`endif
        launch_state = IDLE;
        if (accept) begin
            if (xfer_err)
                launch_state = ERR1;
            else if (WS == 4'd0)
                launch_state = LAST;
            else
                launch_state = WAIT;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        be_d      = be_q;
        mem_we    = 1'b0;
        Hreadyout = 1'b1;
        Hresp     = HRESP_OKAY;
        Hrdata    = '0;

        case (state_q)
            WAIT: begin
                Hreadyout = 1'b0;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = LAST;
            end
            ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = HRESP_ERROR;
                state_d   = ERR2;
            end
            default: begin
                // IDLE, LAST and ERR2 all close a data phase and may start the next one.
                if (state_q == LAST) begin
                    mem_we = write_q;
                    if (!write_q)
                        Hrdata = mem_q[idx_q];
                end
                if (state_q == ERR2)
                    Hresp = HRESP_ERROR;
                state_d = launch_state;
                if (accept) begin
                    idx_d   = Haddr[IDX_W+1:2];
                    write_d = Hwrite;
                    be_d    = lane_en;
                    cnt_d   = WS;
                end
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
        idx_q   <= idx_d;
        write_q <= write_d;
        be_q    <= be_d;
    end

    // A reset landing on the closing edge must not commit the write.
    always_ff @(posedge Hclk) begin
        if (!Hreset && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b])
                    mem_q[idx_q][8*b +: 8] <= Hwdata[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
Word-organised on-chip SRAM AHB slave with a programmable number of wait states and two-cycle ERROR response. Drives one slot of the slave-to-master return path (Hrdata_S[i], Hresp_S[i], Hreadyout_S[i]). Sits directly upstream of the slave-to-master mux and is selected by the address decoder's one-hot Hsel bit.

Parameters:
DATA_WIDTH, 32, bus data width; only 32 is supported.
ADDR_WIDTH, 32, Haddr width.
MEM_DEPTH, 256, number of 32-bit words.
WAIT_STATES, 1, Hreadyout-low cycles inserted per OKAY transfer; range 0..15.

Ports:
Hclk  in  1  bus clock.
Hreset  in  1  synchronous, active-high reset.
Hsel  in  1  slave select from the decoder.
Haddr  in  ADDR_WIDTH  address-phase address.
Htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
Hwrite  in  1  1 = write.
Hsize  in  3  000 = byte, 001 = half, 010 = word.
Hwdata  in  DATA_WIDTH  write data, valid in the data phase.
Hready  in  1  global Hready returned from the mux.
Hreadyout  out  1  this slave's ready.
Hresp  out  2  00 = OKAY, 01 = ERROR.
Hrdata  out  DATA_WIDTH  read data.

Behaviour:
- Reset: state IDLE, Hreadyout=1, Hresp=OKAY, Hrdata=0, wait counter=0. Memory contents are not cleared. A reset asserted mid-transfer abandons the transfer, and a pending write is not committed.
- Accept condition: Hsel && Hready && Htrans[1]. Accepting registers Haddr, Hwrite and Hsize.
- IDLE/BUSY transfers, or Hsel=0: the slave returns a zero-wait OKAY.
- Error check at accept: the transfer is erroneous if any of the following hold:
  - word index Haddr[ADDR_WIDTH-1:2] >= MEM_DEPTH;
  - Hsize > 010;
  - half-word access with Haddr[0]=1;
  - word access with Haddr[1:0] != 00.
- State machine:
  - IDLE: Hreadyout=1, Hresp=OKAY. On accept: erroneous -> ERR1; WAIT_STATES=0 -> LAST; otherwise -> WAIT with counter loaded to WAIT_STATES.
  - WAIT: Hreadyout=0, Hresp=OKAY. Counter decrements each cycle; when the counter equals 1, go to LAST.
  - LAST: Hreadyout=1, Hresp=OKAY.
    - Read: Hrdata = mem[registered index], full word; the master selects lanes.
    - Write: byte lanes from Hwdata are written at the closing edge.
    - The next accept is evaluated in the same cycle (pipelining) and follows the IDLE transition rules. With no accept, go to IDLE.
  - ERR1: Hreadyout=0, Hresp=ERROR, then go to ERR2.
  - ERR2: Hreadyout=1, Hresp=ERROR. No memory access. A next accept is allowed (same rules); otherwise go to IDLE.
- Hrdata is 0 in every cycle except the LAST cycle of a read.
- Byte-lane enables:
  - byte: lane Haddr[1:0];
  - half: lanes {Haddr[1],0} and {Haddr[1],1};
  - word: all four lanes.
- Write-then-read to the same address back-to-back returns the new data, because the write commits before the read's data phase.
- Hready low during WAIT/ERR1 (caused by this slave) blocks any accept. Hready low caused by another slave also blocks the accept.

Optional Feature:
AHB_SRAM_WRPROT_EN
- Defined: adds input Hwprot (1 bit). While Hwprot=1, a write to word index < MEM_DEPTH/4 is treated as erroneous (ERR1/ERR2), and memory is unchanged. Reads are unaffected.
- Undefined: the port is absent and the lower quarter is writable.

Decomposition:
- param_pkg gains:
  - HRESP_OKAY and HRESP_ERROR;
  - HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ and HTRANS_SEQ;
  - HSIZE_BYTE, HSIZE_HALF and HSIZE_WORD;
  - typedef enum sram_state_t {IDLE, WAIT, LAST, ERR1, ERR2}.
- One sub-module: ahb_sram_bytelane, which is combinational. It takes Hsize and Haddr[1:0] and outputs a 4-bit byte-enable plus a misalign flag.

Test Plan:
1. WAIT_STATES=1: write word 0xCAFEBABE @0x10, then read @0x10 -> write data phase shows Hreadyout 0,1; read LAST cycle Hrdata=0xCAFEBABE, Hresp=00.
2. Byte write 0xAA @0x13 over 0x11223344 -> a following word read returns 0xAA223344.
3. Read @ MEM_DEPTH*4 (0x400) -> ERR1 (Hreadyout=0, Hresp=01), then ERR2 (Hreadyout=1, Hresp=01); Hrdata=0.
4. Half-word @0x21 -> two-cycle ERROR; a following word read @0x20 shows the memory unchanged.
5. WAIT_STATES=0: back-to-back NONSEQ writes @0x0/@0x4, then reads @0x0/@0x4 -> Hreadyout stays 1 throughout and the data matches.
6. Hreset=1 during the WAIT of a write @0x8 -> next cycle Hreadyout=1, Hresp=00; a later read @0x8 returns the pre-write value.
